clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter DIV_W, default 8: width of the divisor, the pending register and the phase counter.
REQ-002 Parameter DIV_RESET, default 2: divisor active after reset; values below 2 are clamped to 2 at elaboration.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 en  input  1: count enable; 0 freezes the divider.
REQ-006 div_load  input  1: one-cycle request to load a new divisor.
REQ-007 div_i  input  DIV_W: new divisor, sampled when div_load=1.
REQ-008 clk_out  output  1: divided clock, driven from a register through the root buffer (REQ-030).
REQ-009 tick  output  1: one-cycle clock-enable pulse per divided period.
REQ-010 load_ack  output  1: one-cycle pulse when a pending divisor becomes active.
REQ-011 div_q  output  DIV_W: currently active divisor.

Function
REQ-012 Active divisor D: period D clk cycles; low phase L=ceil(D/2) cycles followed by high phase H=floor(D/2) cycles (D even: 50 % duty; D odd: low one cycle longer).
REQ-013 Phase counter runs 0..D-1 while en=1; wraps D-1 -> 0 (period boundary); clk_out=0 for count<L, 1 for count>=L, registered, no combinational path from inputs.
REQ-014 tick=1 exactly in the cycle where clk_out is high and count=D-1 (last high cycle), otherwise 0.
REQ-015 en=0: counter, clk_out and pending state hold; tick=0; load_ack=0; div_load still captured.
REQ-016 div_load=1 captures div_i into the pending register and sets pending flag; div_i<2 is captured as 2.
REQ-017 A second div_load before application overwrites the pending value (last wins); only one load_ack results.
REQ-018 Pending divisor is applied only at a period boundary (count wraps to 0 with en=1) occurring strictly after the capture cycle; a load in the wrap cycle is applied at the following boundary.
REQ-019 On application: div_q updates, pending flag clears, load_ack=1 for that one cycle, new period starts in low phase; no clk_out pulse shorter than min(old, new) phase.
REQ-020 Loading a value equal to div_q still produces load_ack at the next boundary.
REQ-021 Counter arithmetic is DIV_W bits unsigned; D=2^DIV_W-1 is the maximum; no overflow since count<=D-1.

Reset
REQ-022 rst=1 at a clock edge: count=0, clk_out=0, tick=0, load_ack=0, pending flag=0, div_q=DIV_RESET, regardless of en or div_load.
REQ-023 Reset mid-period discards any pending load; first cycle after rst deasserts is count=0, low phase.

Configuration
REQ-024 Macro CLK_DIV_ROOT_BUF_EN defined: clk_out driven through the sg13g2_buf_16 standard cell instance named clock_root.
REQ-025 Macro undefined: clk_out driven directly from the output register (simulation/FPGA builds); cycle behaviour identical.

Structure
REQ-026 Package clk_div_pkg holds: default DIV_W constant, minimum divisor constant (2), typedef of the divisor type.
REQ-027 Sub-module clk_div_root_buf wraps the buffer selection of REQ-024/025 (ports A, X); clk_div_prog instantiates it once.
REQ-028 Pending register, flag and counter live in clk_div_prog; no other sub-modules.
REQ-029 Target size 120-400 lines of RTL across module, sub-module and package.
REQ-030 clk_out is the only output fed by the buffer; tick, load_ack, div_q are direct register outputs.

Verification
REQ-031 Reset, DIV_RESET=2, en=1 -> clk_out toggles every cycle starting low, tick every 2nd cycle in high phase, div_q=2.
REQ-032 Load div_i=5 mid-period of D=4 -> old period completes; load_ack at next boundary; then low 3, high 2, tick once per 5 cycles.
REQ-033 Loads 6 then 9 in consecutive cycles before boundary -> single load_ack, div_q=9; div_i=0 or 1 -> div_q=2.
REQ-034 en=0 for 7 cycles during high phase of D=8 -> clk_out held high, tick=0, count resumes exactly where stopped.
REQ-035 rst asserted one cycle mid-period with pending load of 12 -> all outputs at reset values, div_q=DIV_RESET, no load_ack afterwards.
REQ-036 Load in the exact wrap cycle -> applied one period later; run with and without CLK_DIV_ROOT_BUF_EN, waveforms identical.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
// Imported by clk_div_prog and clk_div_root_buf.
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF = 8;
  localparam int unsigned DIV_MIN = 2;

  typedef logic [DIV_W_DEF-1:0] div_t;

endpackage

// File: rtl/clk_div_root_buf.sv
// Output buffer for the divided clock: a sg13g2_buf_16 root cell when
// CLK_DIV_ROOT_BUF_EN is defined, a plain wire otherwise.
module clk_div_root_buf
  import clk_div_pkg::*;
(
  input  logic A,
  output logic X
);

`ifdef CLK_DIV_ROOT_BUF_EN
  sg13g2_buf_16 clock_root (
    .A(A),
    .X(X)
  );
`else
  assign X = A;
`endif

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with boundary-synchronous divisor reload.
// Build option: CLK_DIV_ROOT_BUF_EN routes clk_out through a root buffer.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W     = DIV_W_DEF,
  parameter int unsigned DIV_RESET = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_out,
  output logic             tick,
  output logic             load_ack,
  output logic [DIV_W-1:0] div_q
);

  localparam int unsigned DRST =
    (DIV_RESET < DIV_MIN) ? DIV_MIN : DIV_RESET;
  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DRST);
  localparam logic [DIV_W-1:0] MIN_V = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  // Low phase is ceil(D/2) so odd divisors stretch the low half.
  function automatic logic [DIV_W-1:0] low_len(
    input logic [DIV_W-1:0] d
  );
    return (d >> 1) + {{(DIV_W-1){1'b0}}, d[0]};
  endfunction

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] pval_q, pval_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             wrap;

  assign wrap = (cnt_q == div_q - ONE);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pval_d = pval_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    ack_d  = 1'b0;
    if (div_load) begin
      pend_d = 1'b1;
      pval_d = (div_i < MIN_V) ? MIN_V : div_i;
    end
    if (en) begin
      if (wrap) begin
        cnt_d = '0;
        // Only a load captured before this edge is eligible here.
        if (pend_q) begin
          div_d = pval_q;
          ack_d = 1'b1;
          if (!div_load) pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
      clk_d  = (cnt_d >= low_len(div_d));
      tick_d = (cnt_d == div_d - ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= DIV_RST_V;
      pval_q <= DIV_RST_V;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pval_q <= pval_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
    end
  end

  clk_div_root_buf u_root_buf (
    .A(clk_q),
    .X(clk_out)
  );

  assign tick     = tick_q;
  assign load_ack = ack_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed, table-driven bench for clk_div_prog (default parameters).
module tb_clk_div_prog;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_i = '0;
  logic         clk_out;
  logic         tick;
  logic         load_ack;
  logic [W-1:0] div_q;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic         r;
    logic         e;
    logic         l;
    logic [W-1:0] d;
    logic         oc;
    logic         ot;
    logic         oa;
    logic [W-1:0] od;
  } vec_t;

  vec_t tbl[$];

  clk_div_prog dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .div_load(div_load),
    .div_i(div_i),
    .clk_out(clk_out),
    .tick(tick),
    .load_ack(load_ack),
    .div_q(div_q)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, e, l, input logic [W-1:0] d,
                     input logic oc, ot, oa, input logic [W-1:0] od);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.d = d;
    v.oc = oc; v.ot = ot; v.oa = oa; v.od = od;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, e, l, input logic [W-1:0] d);
    @(negedge clk);
    rst = r; en = e; div_load = l; div_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic c, t, a,
                     input logic [W-1:0] d);
    cmp({tag, ".clk_out"}, 32'(clk_out), 32'(c));
    cmp({tag, ".tick"}, 32'(tick), 32'(t));
    cmp({tag, ".load_ack"}, 32'(load_ack), 32'(a));
    cmp({tag, ".div_q"}, 32'(div_q), 32'(d));
  endtask

  initial begin
    int highs;
    int ticks;

    // reset with en and a load present: load must be dropped
    add(1, 1, 1, 7,   0, 0, 0, 2);
    // D=2 free run
    add(0, 1, 0, 0,   1, 1, 0, 2);
    add(0, 1, 0, 0,   0, 0, 0, 2);
    add(0, 1, 0, 0,   1, 1, 0, 2);
    add(0, 1, 0, 0,   0, 0, 0, 2);
    // load 4
    add(0, 1, 1, 4,   1, 1, 0, 2);
    add(0, 1, 0, 0,   0, 0, 1, 4);
    add(0, 1, 0, 0,   0, 0, 0, 4);
    add(0, 1, 0, 0,   1, 0, 0, 4);
    add(0, 1, 0, 0,   1, 1, 0, 4);
    add(0, 1, 0, 0,   0, 0, 0, 4);
    // load 5 mid-period of D=4
    add(0, 1, 1, 5,   0, 0, 0, 4);
    add(0, 1, 0, 0,   1, 0, 0, 4);
    add(0, 1, 0, 0,   1, 1, 0, 4);
    add(0, 1, 0, 0,   0, 0, 1, 5);
    add(0, 1, 0, 0,   0, 0, 0, 5);
    add(0, 1, 0, 0,   0, 0, 0, 5);
    add(0, 1, 0, 0,   1, 0, 0, 5);
    add(0, 1, 0, 0,   1, 1, 0, 5);
    add(0, 1, 0, 0,   0, 0, 0, 5);
    // loads 6 then 9 back to back
    add(0, 1, 1, 6,   0, 0, 0, 5);
    add(0, 1, 1, 9,   0, 0, 0, 5);
    add(0, 1, 0, 0,   1, 0, 0, 5);
    add(0, 1, 0, 0,   1, 1, 0, 5);
    add(0, 1, 0, 0,   0, 0, 1, 9);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 0, 9);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1, 0, 0, 9);
    add(0, 1, 0, 0,   1, 1, 0, 9);
    add(0, 1, 0, 0,   0, 0, 0, 9);
    // load 0 -> clamped to 2
    add(0, 1, 1, 0,   0, 0, 0, 9);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, 9);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1, 0, 0, 9);
    add(0, 1, 0, 0,   1, 1, 0, 9);
    add(0, 1, 0, 0,   0, 0, 1, 2);
    add(0, 1, 0, 0,   1, 1, 0, 2);
    add(0, 1, 0, 0,   0, 0, 0, 2);
    // load 1 -> 2, equal to active, still acked
    add(0, 1, 1, 1,   1, 1, 0, 2);
    add(0, 1, 0, 0,   0, 0, 1, 2);
    add(0, 1, 0, 0,   1, 1, 0, 2);
    // load 3 exactly in the wrap cycle
    add(0, 1, 1, 3,   0, 0, 0, 2);
    add(0, 1, 0, 0,   1, 1, 0, 2);
    add(0, 1, 0, 0,   0, 0, 1, 3);
    add(0, 1, 0, 0,   0, 0, 0, 3);
    add(0, 1, 0, 0,   1, 1, 0, 3);
    add(0, 1, 0, 0,   0, 0, 0, 3);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].d);
      chk($sformatf("vec%0d", i), tbl[i].oc, tbl[i].ot,
          tbl[i].oa, tbl[i].od);
    end

    // switch to D=8, freeze 7 cycles in high phase, load 2 while frozen
    drive(0, 1, 1, 8); chk("d8_c1", 0, 0, 0, 3);
    drive(0, 1, 0, 0); chk("d8_c2", 1, 1, 0, 3);
    drive(0, 1, 0, 0); chk("d8_ack", 0, 0, 1, 8);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 0, 0);
      chk($sformatf("d8_run%0d", i), (i >= 4), 0, 0, 8);
    end
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, (i == 2), 2);
      chk($sformatf("frz%0d", i), 1, 0, 0, 8);
    end
    drive(0, 1, 0, 0); chk("res_c6", 1, 0, 0, 8);
    drive(0, 1, 0, 0); chk("res_c7", 1, 1, 0, 8);
    drive(0, 1, 0, 0); chk("res_wrap", 0, 0, 1, 2);

    // en drop on the tick cycle suppresses tick
    drive(0, 1, 0, 0); chk("tk_on", 1, 1, 0, 2);
    drive(0, 0, 0, 0); chk("tk_frz", 1, 0, 0, 2);
    drive(0, 1, 0, 0); chk("tk_wrap", 0, 0, 0, 2);

    // reset mid-period discards pending 12
    drive(0, 1, 1, 12); chk("rp_load", 1, 1, 0, 2);
    drive(1, 1, 0, 0);  chk("rp_rst", 0, 0, 0, 2);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0);
      chk($sformatf("rp_after%0d", i), (i % 2 == 0),
          (i % 2 == 0), 0, 2);
    end

    // maximum divisor 255: 128 low, 127 high, one tick
    drive(0, 1, 1, 255); chk("mx_load", 1, 1, 0, 2);
    drive(0, 1, 0, 0);   chk("mx_ack", 0, 0, 1, 255);
    highs = 0;
    ticks = 0;
    for (int i = 0; i < 255; i++) begin
      drive(0, 1, 0, 0);
      if (clk_out === 1'b1) highs++;
      if (tick === 1'b1) ticks++;
      if (i == 0) cmp("mx_first_low", 32'(clk_out), 32'd0);
    end
    cmp("mx_highs", 32'(highs), 32'd127);
    cmp("mx_ticks", 32'(ticks), 32'd1);
    chk("mx_end", 0, 0, 0, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
